// File: rtl/uart_cmd_pkg.sv
// Shared constants and helpers for the UART command-frame controller.
// Frame: SYNC, CMD, ADDR, LEN, payload[LEN], CSUM; all bytes except SYNC sum to 0 mod 256.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h01;

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_ADDR    = 3'd2;
    localparam logic [2:0] ST_LEN     = 3'd3;
    localparam logic [2:0] ST_PAYLOAD = 3'd4;
    localparam logic [2:0] ST_CSUM    = 3'd5;
    localparam logic [2:0] ST_COMMIT  = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_CMD  = 3'd1;
    localparam logic [2:0] ERR_BAD_LEN  = 3'd2;
    localparam logic [2:0] ERR_BAD_CSUM = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_OVERRUN  = 3'd5;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    function automatic logic is_busy(input logic [2:0] st);
        return (st != ST_HUNT) && (st != ST_DONE);
    endfunction

    // Buffer index width; the buffer is rounded up to a power of two so any index is in range.
    function automatic int buf_aw(input int max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload buffer: one write port at the parse index, one combinational read port at the commit index.
module cmd_payload_buf
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int AW      = buf_aw(MAX_LEN)
) (
    input  logic          i_Clock,
    input  logic          i_We,
    input  logic [AW-1:0] i_Wr_Idx,
    input  logic [7:0]    i_Wr_Data,
    input  logic [AW-1:0] i_Rd_Idx,
    output logic [7:0]    o_Rd_Data
);

    logic [7:0] mem_q [0:(1<<AW)-1];

    // Payload storage; contents are don't-care after reset, so no reset is applied.
    always_ff @(posedge i_Clock) begin
        if (i_We) begin
            mem_q[i_Wr_Idx] <= i_Wr_Data;
        end
    end

    assign o_Rd_Data = mem_q[i_Rd_Idx];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses framed write commands from the UART receiver, validates the checksum,
// then replays the buffered payload as register writes over a valid/ready port.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 100000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter logic [7:0] CMD_WRITE    = CMD_WRITE_DEF
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_Valid,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    input  logic       i_Wr_Ready,
    output logic       o_Busy,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err,
    output logic [2:0] o_Err_Code
);

    localparam int            AW        = buf_aw(MAX_LEN);
    localparam int            TW        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    logic [2:0]    state_q, state_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    start_q, start_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    k_q, k_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wr_valid_q, wr_valid_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [2:0]    err_code_q, err_code_d;

    logic          buf_we_s;
    logic [AW-1:0] buf_rd_idx_s;
    logic [7:0]    buf_rd_data_s;
    logic [7:0]    sum_next_s;
    logic          in_frame_s;

    cmd_payload_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
        .i_Clock   (i_Clock),
        .i_We      (buf_we_s),
        .i_Wr_Idx  (idx_q[AW-1:0]),
        .i_Wr_Data (i_Rx_Byte),
        .i_Rd_Idx  (buf_rd_idx_s),
        .o_Rd_Data (buf_rd_data_s)
    );

    assign sum_next_s = csum_add(sum_q, i_Rx_Byte);
    assign in_frame_s = (state_q >= ST_CMD) && (state_q <= ST_CSUM);

    // Next-state logic: frame parser, commit sequencer and inter-byte timeout.
    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        start_d      = start_q;
        len_d        = len_q;
        idx_d        = idx_q;
        k_d          = k_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        buf_we_s     = 1'b0;
        buf_rd_idx_s = k_q[AW-1:0];

        if (in_frame_s && !i_Rx_DV) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = '0;
        end

        case (state_q)
            ST_HUNT, ST_DONE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                    sum_d   = 8'h00;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_CMD: begin
                if (i_Rx_DV && (i_Rx_Byte == CMD_WRITE)) begin
                    state_d = ST_ADDR;
                    sum_d   = sum_next_s;
                end else if (i_Rx_DV) begin
                    state_d    = ST_HUNT;
                    err_d      = 1'b1;
                    err_code_d = ERR_BAD_CMD;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ADDR: begin
                if (i_Rx_DV) begin
                    state_d = ST_LEN;
                    start_d = i_Rx_Byte;
                    sum_d   = sum_next_s;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN: begin
                if (i_Rx_DV && (i_Rx_Byte != 8'h00) && (i_Rx_Byte <= MAX_LEN_B)) begin
                    state_d = ST_PAYLOAD;
                    len_d   = i_Rx_Byte;
                    idx_d   = 8'h00;
                    sum_d   = sum_next_s;
                end else if (i_Rx_DV) begin
                    state_d    = ST_HUNT;
                    err_d      = 1'b1;
                    err_code_d = ERR_BAD_LEN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_PAYLOAD: begin
                if (i_Rx_DV) begin
                    buf_we_s = 1'b1;
                    idx_d    = idx_q + 8'd1;
                    sum_d    = sum_next_s;
                    state_d  = ((idx_q + 8'd1) == len_q) ? ST_CSUM : ST_PAYLOAD;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CSUM: begin
                if (i_Rx_DV && (sum_next_s == 8'h00)) begin
                    state_d      = ST_COMMIT;
                    k_d          = 8'h00;
                    buf_rd_idx_s = '0;
                    wr_valid_d   = 1'b1;
                    wr_addr_d    = start_q;
                    wr_data_d    = buf_rd_data_s;
                end else if (i_Rx_DV) begin
                    state_d    = ST_HUNT;
                    err_d      = 1'b1;
                    err_code_d = ERR_BAD_CSUM;
                end else begin
                    state_d = state_q;
                end
            end
            ST_COMMIT: begin
                // A byte arriving now is dropped but the commit still runs to completion.
                if (i_Rx_DV) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end else begin
                    err_d = 1'b0;
                end
                if (wr_valid_q && i_Wr_Ready && (k_q == (len_q - 8'd1))) begin
                    state_d    = ST_DONE;
                    wr_valid_d = 1'b0;
                    done_d     = 1'b1;
                end else if (wr_valid_q && i_Wr_Ready) begin
                    k_d          = k_q + 8'd1;
                    buf_rd_idx_s = k_q[AW-1:0] + AW'(1'b1);
                    wr_addr_d    = wr_addr_q + 8'd1;
                    wr_data_d    = buf_rd_data_s;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = ST_HUNT;
                wr_valid_d = 1'b0;
            end
        endcase

        if (in_frame_s && !i_Rx_DV && (tmo_q == TO_LAST)) begin
            state_d    = ST_HUNT;
            tmo_d      = '0;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else begin
            err_d = err_d;
        end

        busy_d = is_busy(state_d);
    end

    // State and registered outputs; async reset also drops o_Wr_Valid mid-commit.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= ST_HUNT;
            sum_q      <= 8'h00;
            start_q    <= 8'h00;
            len_q      <= 8'h00;
            idx_q      <= 8'h00;
            k_q        <= 8'h00;
            tmo_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            start_q    <= start_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            tmo_q      <= tmo_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign o_Wr_Valid   = wr_valid_q;
    assign o_Wr_Addr    = wr_addr_q;
    assign o_Wr_Data    = wr_data_q;
    assign o_Busy       = busy_q;
    assign o_Frame_Done = done_q;
    assign o_Frame_Err  = err_q;
    assign o_Err_Code   = err_code_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl (MAX_LEN=16, TIMEOUT_CLKS=50).
module tb_uart_cmd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;
    logic       done;
    logic       ferr;
    logic [2:0] ecode;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] log_addr [0:31];
    logic [7:0] log_data [0:31];
    int         log_n = 0;
    int         err_pulses = 0;
    int         done_pulses = 0;

    uart_cmd_ctrl #(.MAX_LEN(16), .TIMEOUT_CLKS(50)) dut (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_Rx_DV      (rx_dv),
        .i_Rx_Byte    (rx_byte),
        .o_Wr_Valid   (wr_valid),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_Data    (wr_data),
        .i_Wr_Ready   (wr_ready),
        .o_Busy       (busy),
        .o_Frame_Done (done),
        .o_Frame_Err  (ferr),
        .o_Err_Code   (ecode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted-write log and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_valid && wr_ready && log_n < 32) begin
            log_addr[log_n] = wr_addr;
            log_data[log_n] = wr_data;
            log_n = log_n + 1;
        end
        if (ferr) err_pulses = err_pulses + 1;
        if (done) done_pulses = done_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_good();
        send(8'hA5); send(8'h01); send(8'h10); send(8'h02);
        send(8'hAA); send(8'h55); send(8'hEE);
    endtask

    initial begin
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; wr_ready = 1'b1;
        #1;
        check("rst_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, ferr}, 32'd0);
        check("rst_code",  {29'd0, ecode}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Non-sync noise in HUNT is ignored silently.
        send(8'h3C);
        check("hunt_noise_busy", {31'd0, busy}, 32'd0);
        check("hunt_noise_err",  {31'd0, ferr}, 32'd0);

        // 1: good frame, two back-to-back writes.
        send(8'hA5);
        check("s1_busy", {31'd0, busy}, 32'd1);
        send(8'h01); send(8'h10); send(8'h02); send(8'hAA); send(8'h55); send(8'hEE);
        check("s1_w0", {23'd0, wr_valid, wr_addr, wr_data}, {23'd0, 1'b1, 8'h10, 8'hAA});
        tick();
        check("s1_w1", {23'd0, wr_valid, wr_addr, wr_data}, {23'd0, 1'b1, 8'h11, 8'h55});
        tick();
        check("s1_valid_off", {31'd0, wr_valid}, 32'd0);
        check("s1_done", {31'd0, done}, 32'd1);
        tick();
        check("s1_done_pulse", {31'd0, done}, 32'd0);
        check("s1_busy_off", {31'd0, busy}, 32'd0);
        check("s1_no_err", err_pulses, 32'd0);
        check("s1_nwrites", log_n, 32'd2);

        // 2: backpressure with address wrap; checksum of 01 FF 02 11 22 is 35, so CSUM = CB.
        wr_ready = 1'b0;
        send(8'hA5); send(8'h01); send(8'hFF); send(8'h02); send(8'h11); send(8'h22); send(8'hCB);
        for (int i = 0; i < 5; i++) begin
            check("s2_hold", {23'd0, wr_valid, wr_addr, wr_data}, {23'd0, 1'b1, 8'hFF, 8'h11});
            if (i < 4) tick();
        end
        wr_ready = 1'b1;
        tick();
        check("s2_wrap", {23'd0, wr_valid, wr_addr, wr_data}, {23'd0, 1'b1, 8'h00, 8'h22});
        tick();
        check("s2_done", {31'd0, done}, 32'd1);
        check("s2_nwrites", log_n, 32'd4);
        check("s2_log0", {16'd0, log_addr[2], log_data[2]}, {16'd0, 8'hFF, 8'h11});
        check("s2_log1", {16'd0, log_addr[3], log_data[3]}, {16'd0, 8'h00, 8'h22});
        tick();

        // 3: bad checksum, then a good frame is still accepted.
        send(8'hA5); send(8'h01); send(8'h10); send(8'h02); send(8'hAA); send(8'h55); send(8'hEF);
        check("s3_err", {28'd0, ferr, ecode}, {28'd0, 1'b1, 3'd3});
        check("s3_busy", {31'd0, busy}, 32'd0);
        tick();
        check("s3_err_pulse", {28'd0, ferr, ecode}, {28'd0, 1'b0, 3'd3});
        check("s3_no_write", log_n, 32'd4);
        send_good();
        tick(); tick(); tick();
        check("s3_nwrites", log_n, 32'd6);
        check("s3_log", {log_addr[4], log_data[4], log_addr[5], log_data[5]},
              {8'h10, 8'hAA, 8'h11, 8'h55});

        // 4: length zero, bad command, length over MAX_LEN.
        send(8'hA5); send(8'h01); send(8'h10); send(8'h00);
        check("s4_len0", {28'd0, ferr, ecode}, {28'd0, 1'b1, 3'd2});
        tick();
        send(8'hA5); send(8'h02);
        check("s4_cmd", {28'd0, ferr, ecode}, {28'd0, 1'b1, 3'd1});
        tick();
        send(8'hA5); send(8'h01); send(8'h10); send(8'h11);
        check("s4_len17", {28'd0, ferr, ecode}, {28'd0, 1'b1, 3'd2});
        tick();
        check("s4_err_count", err_pulses, 32'd4);

        // 5: timeout after 50 idle clocks.
        send(8'hA5); send(8'h01); send(8'h10);
        for (int i = 0; i < 49; i++) tick();
        check("s5_before", {30'd0, busy, ferr}, {30'd0, 1'b1, 1'b0});
        tick();
        check("s5_err", {28'd0, ferr, ecode}, {28'd0, 1'b1, 3'd4});
        check("s5_busy_off", {31'd0, busy}, 32'd0);
        tick();

        // 6a: overrun during COMMIT; both writes still happen.
        wr_ready = 1'b0;
        send_good();
        send(8'h33);
        check("s6_overrun", {28'd0, ferr, ecode}, {28'd0, 1'b1, 3'd5});
        check("s6_still_valid", {23'd0, wr_valid, wr_addr, wr_data}, {23'd0, 1'b1, 8'h10, 8'hAA});
        wr_ready = 1'b1;
        tick(); tick();
        check("s6_done", {31'd0, done}, 32'd1);
        check("s6_nwrites", log_n, 32'd8);
        check("s6_log", {log_addr[6], log_data[6], log_addr[7], log_data[7]},
              {8'h10, 8'hAA, 8'h11, 8'h55});
        tick();

        // 6b: reset asserted mid-COMMIT drops o_Wr_Valid immediately.
        wr_ready = 1'b0;
        send_good();
        check("s6_pre_rst", {31'd0, wr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_rst_valid", {31'd0, wr_valid}, 32'd0);
        check("s6_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        wr_ready = 1'b1;
        tick(); tick();
        check("s6_hunt", {30'd0, busy, wr_valid}, 32'd0);
        check("s6_no_partial", log_n, 32'd8);
        send_good();
        tick(); tick(); tick();
        check("s6_after_rst", log_n, 32'd10);
        check("s6_done_total", done_pulses, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
